// File: rtl/swc_pkg.sv
// Shared definitions for the sample window collector: default widths, window
// length and the collector state encoding.
package swc_pkg;

  localparam int DEFAULT_DATAWIDTH = 16;
  localparam int DEFAULT_SHIFT_AMT = 1;
  localparam int WINDOW_LEN        = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } swc_state_e;

endpackage : swc_pkg

// File: rtl/swc_shift_window.sv
// WINDOW_LEN-deep sample shift register; taps_o shows the window as it will be
// after this cycle's load, so the caller can capture a completed window directly.
module swc_shift_window
  import swc_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic [DATAWIDTH-1:0] taps_o [WINDOW_LEN]
);

  logic [DATAWIDTH-1:0] win_q [WINDOW_LEN];
  logic [DATAWIDTH-1:0] win_d [WINDOW_LEN];

  // Oldest sample at index 0, newest at WINDOW_LEN-1.
  always_comb begin
    win_d = win_q;
    if (load_i) begin
      for (int k = 0; k < WINDOW_LEN - 1; k++) begin
        win_d[k] = win_q[k + 1];
      end
      win_d[WINDOW_LEN-1] = data_i;
    end
  end

  // NOTE: the storage is cleared on reset so a window cut short by rst can never leak stale samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '{default: '0};
    end else begin
      win_q <= win_d;
    end
  end

  assign taps_o = win_d;

endmodule : swc_shift_window

// File: rtl/sample_window_collector.sv
// Serial-to-parallel window collector feeding the 8-input averager.
// Build option: SWC_SLIDING_WINDOW_EN selects overlapping (sliding) windows.
module sample_window_collector
  import swc_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int SHIFT_AMT = DEFAULT_SHIFT_AMT,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic [7:0]           sa,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [CNTWIDTH-1:0]  frame_count
);

`ifdef SWC_SLIDING_WINDOW_EN
  // One extra bit so the fill counter can saturate at WINDOW_LEN.
  localparam int FILL_W = $clog2(WINDOW_LEN) + 1;
`else
  localparam int FILL_W = $clog2(WINDOW_LEN);
`endif
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WINDOW_LEN - 1);

  swc_state_e           state_q, state_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [CNTWIDTH-1:0]  frame_count_q, frame_count_d;
  logic [DATAWIDTH-1:0] out_q [WINDOW_LEN];
  logic [DATAWIDTH-1:0] out_d [WINDOW_LEN];
  logic [DATAWIDTH-1:0] next_win [WINDOW_LEN];
  logic                 accept;
  logic                 handoff;

  assign accept  = in_valid && in_ready;
  assign handoff = frame_valid_q && frame_ready;

  swc_shift_window #(
    .DATAWIDTH(DATAWIDTH)
  ) u_window (
    .clk   (clk),
    .rst   (rst),
    .load_i(accept),
    .data_i(in_data),
    .taps_o(next_win)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    frame_valid_d = frame_valid_q;
    frame_count_d = frame_count_q;
    out_d         = out_q;
    in_ready      = 1'b0;

    if (handoff) begin
      frame_valid_d = 1'b0;
      frame_count_d = frame_count_q + 1'b1;
    end

`ifdef SWC_SLIDING_WINDOW_EN
    in_ready = !frame_valid_q || frame_ready;
    if (accept) begin
      if (state_q == HOLD || fill_q == LAST_FILL) begin
        out_d         = next_win;
        frame_valid_d = 1'b1;
        fill_d        = FILL_W'(WINDOW_LEN);
        state_d       = HOLD;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end
`else
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (accept) begin
          if (fill_q == LAST_FILL) begin
            out_d         = next_win;
            frame_valid_d = 1'b1;
            fill_d        = '0;
            state_d       = HOLD;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Input is throttled by the consumer so a stalled window is never overwritten.
        in_ready = frame_ready;
        if (frame_ready) begin
          state_d = FILL;
          fill_d  = accept ? FILL_W'(1) : '0;
        end
      end
      default: state_d = FILL;
    endcase
`endif
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      fill_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      out_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
      out_q         <= out_d;
    end
  end

  assign a           = out_q[0];
  assign b           = out_q[1];
  assign c           = out_q[2];
  assign d           = out_q[3];
  assign e           = out_q[4];
  assign f           = out_q[5];
  assign g           = out_q[6];
  assign h           = out_q[7];
  assign sa          = 8'(SHIFT_AMT);
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;

endmodule : sample_window_collector

// File: doc/sample_window_collector.md
Name: sample_window_collector

Overview:
- Upstream feeder for the 8-input signed averager (adder tree, then three shift stages, then output register).
- Accepts a serial stream of 16-bit signed samples on a valid/ready handshake and assembles them into 8-sample windows.
- Presents each window in parallel on outputs a..h, with a frame_valid/frame_ready handshake and a constant shift-amount output sa for the averager.
- Decouples a one-sample-per-cycle source from the parallel averager datapath.

Parameters:
- DATAWIDTH, 16, sample width in bits (two's complement).
- SHIFT_AMT, 1, value driven on sa; 1 per stage gives a divide-by-8 across three shift stages.
- CNTWIDTH, 16, width of the frame_count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATAWIDTH  signed sample.
- in_valid  input  1  source has a sample.
- in_ready  output  1  collector accepts the sample this cycle.
- a, b, c, d, e, f, g, h  output  DATAWIDTH each  window samples; a = oldest, h = newest.
- sa  output  8  shift amount, constant SHIFT_AMT.
- frame_valid  output  1  a..h hold a complete window.
- frame_ready  input  1  consumer takes the window this cycle.
- frame_count  output  CNTWIDTH  number of frames handed off; wraps modulo 2^CNTWIDTH.

Behaviour:
- Reset:
  - Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising clk edge.
  - On reset: a..h = 0, frame_valid = 0, frame_count = 0, fill counter = 0, state = FILL.
  - Reset takes priority over every other event, including mid-fill and a pending frame; partial windows are discarded.
- Accept rule: a sample is accepted when in_valid && in_ready at the clock edge.
- Internal storage: shift register win[0..7]; each accept shifts win[k] <= win[k+1] and win[7] <= in_data.
- FILL state:
  - in_ready = 1.
  - A 3-bit fill counter counts accepts.
  - On the 8th accept (counter = 7): a..h <= {win[1..7], in_data}, frame_valid <= 1, counter <= 0, go to HOLD.
  - First-sample-to-frame_valid latency: frame_valid asserts on the cycle after the 8th accept.
- HOLD state:
  - frame_valid = 1; a..h stable until handshake.
  - in_ready = frame_ready, so there is no new input while the window is stalled.
  - On frame_ready: frame_valid <= 0 and frame_count increments.
  - If a sample is accepted in the same cycle, it becomes the first sample of the next window (counter <= 1) and the state goes to FILL.
  - If frame_ready and no accept: go to FILL with counter = 0.
- frame_ready while frame_valid = 0 is ignored.
- in_valid while in_ready = 0: no state change; the source must hold its data.
- sa = SHIFT_AMT zero-extended to 8 bits, driven combinationally and unaffected by reset.
- frame_count wraps from all-ones to 0 with no flag.
- No arithmetic on samples; data passes bit-exact.

Optional Feature:
- Macro: SWC_SLIDING_WINDOW_EN.
- Defined:
  - After the first full window, every accepted sample produces a new frame of the last 8 samples: shift, then a..h <= updated window, frame_valid <= 1.
  - in_ready = !frame_valid || frame_ready, so a consume and a new sample in the same cycle yield back-to-back frames.
  - Fill counter saturates at 8 and is cleared only by rst.
- Undefined: non-overlapping windows exactly as above.

Decomposition:
- Shared package swc_pkg:
  - DATAWIDTH default.
  - WINDOW_LEN = 8.
  - State enum {FILL, HOLD}.
  - SHIFT_AMT default.
- Natural sub-module: swc_shift_window, the 8-deep DATAWIDTH shift register with load enable and parallel tap outputs.
- The top level holds the FSM, handshake logic and counters.

Test Plan:
- Reset then stream 1..8 with in_valid held high and frame_ready = 1 -> cycle after 8th accept: frame_valid = 1, a..h = 1..8, sa = 1, frame_count becomes 1 the next edge.
- Stream 8 samples with frame_ready = 0 for 5 cycles -> a..h stable, in_ready = 0, 9th sample held off; on frame_ready = 1 the 9th sample is accepted the same cycle and the next frame starts with it.
- Signed data -16'h8000, 16'h7FFF, -1, 0, ... -> outputs bit-exact, no sign alteration.
- Assert rst after 5 accepts -> next frame needs 8 fresh samples; a..h = 0 and frame_valid = 0 until then.
- Force frame_count = 16'hFFFF and complete one frame -> frame_count = 0.
- SWC_SLIDING_WINDOW_EN defined: stream 1..10 with frame_ready = 1 -> frames {1..8}, {2..9}, {3..10} on consecutive handshakes.
